// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
`ifndef ALEN
`define ALEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package mem_arb_pkg;

  typedef struct packed {
    logic                    valid;
    logic [`ALEN-1:0]        pc;
    logic [1:0][`XLEN-1:0]   inst;
  } If_id_pkt_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  // Consecutive LS grants tolerated while fetch is waiting.
  localparam logic [2:0] STARVE_LIMIT = 3'd4;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - fetch/LS arbitration with starvation counter
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic if_req,
  input  logic if_flush,
  input  logic ls_req,
  output logic grant_if,
  output logic grant_ls
);

  logic [2:0] starve_cnt;
  logic       fetch_ok;
  logic       starved;

  // A flush in the grant cycle withdraws fetch, letting LS take the slot.
  always_comb begin
    fetch_ok = if_req && !if_flush;
    starved  = (starve_cnt == STARVE_LIMIT);
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (arb_en) begin
      if (fetch_ok && (starved || !ls_req)) begin
        grant_if = 1'b1;
      end else if (ls_req) begin
        grant_ls = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (grant_if) begin
      starve_cnt <= 3'd0;
    end else if (grant_ls && if_req && !starved) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - shares one memory port between instruction fetch and load/store
module mem_arb
  import mem_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [`ALEN-1:0]      if_addr,
  input  logic                  if_flush,
  output logic                  if_valid,
  output logic [1:0][`XLEN-1:0] if_inst,
  output logic                  if_busy,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [`ALEN-1:0]      ls_addr,
  input  logic [`XLEN-1:0]      ls_wdata,
  output logic                  ls_ack,
  output logic [`XLEN-1:0]      ls_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [`ALEN-1:0]      mem_addr,
  output logic [`XLEN-1:0]      mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [1:0][`XLEN-1:0] mem_rdata
);

  arb_state_t state;
  logic       owner_if;
  logic       drop;
  logic       grant_if;
  logic       grant_ls;
  logic       arb_en;

  assign arb_en  = (state == ARB_IDLE);
  assign if_busy = if_req && !if_valid;

  mem_arb_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .arb_en   (arb_en),
    .if_req   (if_req),
    .if_flush (if_flush),
    .ls_req   (ls_req),
    .grant_if (grant_if),
    .grant_ls (grant_ls)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner_if  <= 1'b0;
      drop      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      if_inst   <= '0;
      ls_ack    <= 1'b0;
      ls_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      ls_ack   <= 1'b0;
      case (state)
        ARB_IDLE: begin
          drop <= 1'b0;
          if (grant_if) begin
            owner_if  <= 1'b1;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_req   <= 1'b1;
            state     <= ARB_ISSUE;
          end else if (grant_ls) begin
            owner_if  <= 1'b0;
            mem_addr  <= ls_addr;
            mem_we    <= ls_we;
            mem_wdata <= ls_wdata;
            mem_req   <= 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (owner_if && if_flush) drop <= 1'b1;
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (owner_if && if_flush) drop <= 1'b1;
          if (mem_rvalid) begin
            state <= ARB_IDLE;
            // A flush landing with the response still kills it.
            if (owner_if) begin
              if (!(drop || if_flush)) begin
                if_valid <= 1'b1;
                if_inst  <= mem_rdata;
              end
            end else begin
              ls_ack   <= 1'b1;
              ls_rdata <= mem_we ? '0 : mem_rdata[0];
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb
`ifndef ALEN
`define ALEN 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arb;

  localparam int AW     = `ALEN;
  localparam int XW     = `XLEN;
  localparam int STARVE = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [XW-1:0] wdata;
  } ls_op_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                if_req = 1'b0;
  logic [AW-1:0]       if_addr = '0;
  logic                if_flush = 1'b0;
  logic                if_valid;
  logic [1:0][XW-1:0]  if_inst;
  logic                if_busy;
  logic                ls_req = 1'b0;
  logic                ls_we = 1'b0;
  logic [AW-1:0]       ls_addr = '0;
  logic [XW-1:0]       ls_wdata = '0;
  logic                ls_ack;
  logic [XW-1:0]       ls_rdata;
  logic                mem_req;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [XW-1:0]       mem_wdata;
  logic                mem_ready = 1'b1;
  logic                mem_rvalid = 1'b0;
  logic [1:0][XW-1:0]  mem_rdata = '0;

  ls_op_t              ls_todo[$];
  logic [AW-1:0]       if_todo[$];
  logic [XW-1:0]       ls_log[$];
  int                  ls_ack_cyc[$];
  logic [1:0][XW-1:0]  if_log[$];
  logic [AW-1:0]       acc_addr[$];
  logic                acc_we[$];
  logic [XW-1:0]       acc_wdata[$];
  logic [AW-1:0]       pend_addr[$];
  int                  pend_due[$];

  int cyc = 0;
  int resp_delay = 0;
  int ready_hold = 0;
  bit ready_rand = 0;
  bit ls_gaps = 0;
  int checks = 0;
  int failures = 0;

  mem_arb dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_busy    (if_busy),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_ack     (ls_ack),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [1:0][XW-1:0] mem_word(input logic [AW-1:0] a);
    logic [1:0][XW-1:0] w;
    w[1] = XW'(~a);
    w[0] = XW'(a ^ 32'h1234_5678);
    return w;
  endfunction

  function automatic logic [XW-1:0] ls_expect(input ls_op_t op);
    logic [1:0][XW-1:0] w;
    w = mem_word(op.addr);
    return op.we ? '0 : w[0];
  endfunction

  // One clock: memory responder plus the two requesters.
  task automatic tick();
    ls_op_t op;
    if (mem_req === 1'b1 && mem_ready === 1'b1) begin
      acc_addr.push_back(mem_addr);
      acc_we.push_back(mem_we);
      acc_wdata.push_back(mem_wdata);
      pend_addr.push_back(mem_addr);
      pend_due.push_back(cyc + 1 + resp_delay);
    end
    @(posedge clk);
    #1;
    cyc++;
    mem_rvalid = 1'b0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(pend_addr[0]);
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    if (ready_hold > 0) begin
      mem_ready = 1'b0;
      ready_hold--;
    end else begin
      mem_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (ls_ack === 1'b1) begin
      ls_log.push_back(ls_rdata);
      ls_ack_cyc.push_back(cyc);
      ls_req = 1'b0;
    end
    if (if_valid === 1'b1) begin
      if_log.push_back(if_inst);
      if_req = 1'b0;
    end
    if (!ls_req && ls_todo.size() > 0 && (!ls_gaps || $urandom_range(0, 1) == 1)) begin
      op       = ls_todo.pop_front();
      ls_req   = 1'b1;
      ls_we    = op.we;
      ls_addr  = op.addr;
      ls_wdata = op.wdata;
    end
    if (!if_req && if_todo.size() > 0) begin
      if_addr = if_todo.pop_front();
      if_req  = 1'b1;
    end
  endtask

  task automatic serve(input int max_cyc, input bit rand_delay, output bit ok);
    for (int i = 0; i < max_cyc; i++) begin
      if (ls_todo.size() == 0 && if_todo.size() == 0 && !ls_req && !if_req) break;
      if (rand_delay) resp_delay = $urandom_range(0, 2);
      tick();
    end
    ok = (ls_todo.size() == 0 && if_todo.size() == 0 && !ls_req && !if_req);
  endtask

  task automatic clear_logs();
    ls_log.delete();
    ls_ack_cyc.delete();
    if_log.delete();
    acc_addr.delete();
    acc_we.delete();
    acc_wdata.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ls_req = 1'b0;
    if_req = 1'b0;
    if_flush = 1'b0;
    ls_todo.delete();
    if_todo.delete();
    ready_rand = 0;
    ls_gaps = 0;
    ready_hold = 0;
    resp_delay = 0;
    tick();
    tick();
    rst = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    clear_logs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({mem_req, mem_we, if_valid, ls_ack, if_busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_valid, ls_ack, if_busy});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem_fields: got %h expected 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({if_inst, ls_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_resp_data: got %h expected 0", {if_inst, ls_rdata});
    end
    rst = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic test_lone_fetch();
    clear_logs();
    if_addr = 32'h10;
    if_req  = 1'b1;
    #0;
    checks++;
    if (if_busy !== 1'b1) begin
      failures++;
      $display("FAIL fetch_busy: got %b expected 1", if_busy);
    end
    tick();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(32'h10)}) begin
      failures++;
      $display("FAIL fetch_issue: got req=%b we=%b addr=%h expected 1 0 10", mem_req, mem_we, mem_addr);
    end
    tick();
    checks++;
    if ({mem_req, if_valid} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_wait: got req=%b valid=%b expected 0 0", mem_req, if_valid);
    end
    tick();
    checks++;
    if (if_valid !== 1'b1 || if_inst !== mem_word(32'h10)) begin
      failures++;
      $display("FAIL fetch_ack_t3: got valid=%b inst=%h expected 1 %h", if_valid, if_inst, mem_word(32'h10));
    end
    tick();
    checks++;
    if ({if_valid, mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL fetch_single_pulse: got valid=%b req=%b expected 0 0", if_valid, mem_req);
    end
  endtask

  task automatic test_collision();
    bit ok;
    ls_op_t op;
    logic [1:0][XW-1:0] w;
    clear_logs();
    op = '{we: 1'b0, addr: 32'h40, wdata: 32'h0};
    ls_todo.push_back(op);
    if_todo.push_back(32'h30);
    tick();
    serve(40, 0, ok);
    checks++;
    if (!ok || acc_addr.size() != 2) begin
      failures++;
      $display("FAIL collision_done: got done=%0d issued=%0d expected 1 2", ok, acc_addr.size());
    end else begin
      checks++;
      if (acc_addr[0] !== 32'h40 || acc_addr[1] !== 32'h30) begin
        failures++;
        $display("FAIL collision_order: got %h,%h expected 40,30", acc_addr[0], acc_addr[1]);
      end
      w = mem_word(32'h30);
      checks++;
      if (ls_log.size() != 1 || if_log.size() != 1 || ls_log[0] !== ls_expect(op) || if_log[0] !== w) begin
        failures++;
        $display("FAIL collision_data: got ls=%0d if=%0d responses expected matching data for 40 and 30",
                 ls_log.size(), if_log.size());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int p;
    clear_logs();
    ls_todo.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    ls_todo.push_back('{we: 1'b0, addr: 32'h204, wdata: 32'h0});
    tick();
    p = cyc;
    serve(40, 0, ok);
    checks++;
    if (!ok || ls_ack_cyc.size() != 2) begin
      failures++;
      $display("FAIL b2b_done: got done=%0d acks=%0d expected 1 2", ok, ls_ack_cyc.size());
    end else begin
      checks++;
      if (ls_ack_cyc[0] != p + 3 || ls_ack_cyc[1] != p + 6) begin
        failures++;
        $display("FAIL b2b_latency: got acks at +%0d,+%0d expected +3,+6", ls_ack_cyc[0] - p, ls_ack_cyc[1] - p);
      end
    end
  endtask

  task automatic test_starvation();
    bit ok;
    logic [AW-1:0] exp_order[$];
    int run = 0;
    int ls_left = 6;
    int li = 0;
    bit f_pend = 1;
    clear_logs();
    for (int i = 0; i < 6; i++) ls_todo.push_back('{we: 1'b0, addr: AW'(32'h100 + 4 * i), wdata: 32'h0});
    if_todo.push_back(32'h50);
    while (ls_left > 0 || f_pend) begin
      if (f_pend && (run == STARVE || ls_left == 0)) begin
        exp_order.push_back(32'h50);
        f_pend = 0;
      end else begin
        exp_order.push_back(AW'(32'h100 + 4 * li));
        li++;
        ls_left--;
        if (f_pend) run++;
      end
    end
    tick();
    serve(100, 0, ok);
    checks++;
    if (!ok || acc_addr.size() != exp_order.size()) begin
      failures++;
      $display("FAIL starve_done: got done=%0d issued=%0d expected 1 %0d", ok, acc_addr.size(), exp_order.size());
    end else begin
      foreach (exp_order[k]) begin
        checks++;
        if (acc_addr[k] !== exp_order[k]) begin
          failures++;
          $display("FAIL starve_order[%0d]: got %h expected %h", k, acc_addr[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_flush_wait();
    bit ok;
    clear_logs();
    resp_delay = 2;
    if_todo.push_back(32'h20);
    for (int i = 0; i < 10 && acc_addr.size() == 0; i++) tick();
    if_flush = 1'b1;
    if_addr  = 32'h80;
    tick();
    if_flush = 1'b0;
    serve(40, 0, ok);
    resp_delay = 0;
    checks++;
    if (!ok || acc_addr.size() != 2 || if_log.size() != 1) begin
      failures++;
      $display("FAIL flush_wait_done: got done=%0d issued=%0d valids=%0d expected 1 2 1",
               ok, acc_addr.size(), if_log.size());
    end else begin
      checks++;
      if (acc_addr[0] !== 32'h20 || acc_addr[1] !== 32'h80) begin
        failures++;
        $display("FAIL flush_wait_addr: got %h,%h expected 20,80", acc_addr[0], acc_addr[1]);
      end
      checks++;
      if (if_log[0] !== mem_word(32'h80)) begin
        failures++;
        $display("FAIL flush_wait_inst: got %h expected %h", if_log[0], mem_word(32'h80));
      end
    end
  endtask

  task automatic test_flush_idle();
    bit ok;
    clear_logs();
    if_addr  = 32'h90;
    if_req   = 1'b1;
    if_flush = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_cancel: got mem_req=%b expected 0", mem_req);
    end
    if_flush = 1'b0;
    if_addr  = 32'hA0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'hA0) begin
      failures++;
      $display("FAIL flush_idle_regrant: got req=%b addr=%h expected 1 a0", mem_req, mem_addr);
    end
    serve(40, 0, ok);
    checks++;
    if (!ok || if_log.size() != 1 || if_log[0] !== mem_word(32'hA0)) begin
      failures++;
      $display("FAIL flush_idle_inst: got done=%0d valids=%0d expected 1 1 with data for a0", ok, if_log.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    ready_hold = 4;
    ls_todo.push_back('{we: 1'b1, addr: 32'h60, wdata: 32'hDEAD_BEEF});
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, AW'(32'h60), XW'(32'hDEAD_BEEF)}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got req=%b we=%b addr=%h wdata=%h expected 1 1 60 deadbeef",
                 i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if_flush = (i == 1);
    end
    if_flush = 1'b0;
    serve(40, 0, ok);
    checks++;
    if (!ok || acc_addr.size() != 1 || ls_log.size() != 1 || ls_log[0] !== '0) begin
      failures++;
      $display("FAIL bp_single_store: got done=%0d issued=%0d acks=%0d expected 1 1 1 with rdata 0",
               ok, acc_addr.size(), ls_log.size());
    end
  endtask

  task automatic test_reset_wait();
    bit ok;
    ls_op_t op;
    clear_logs();
    resp_delay = 1;
    ls_todo.push_back('{we: 1'b0, addr: 32'h70, wdata: 32'h0});
    for (int i = 0; i < 10 && acc_addr.size() == 0; i++) tick();
    rst    = 1'b1;
    ls_req = 1'b0;
    ls_todo.delete();
    tick();
    rst = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, ls_ack, ls_rdata, if_valid, if_inst} !== '0) begin
      failures++;
      $display("FAIL rst_wait_outputs: got nonzero req=%b ack=%b addr=%h expected all 0", mem_req, ls_ack, mem_addr);
    end
    tick();
    checks++;
    if ({mem_req, ls_ack, if_valid, ls_rdata} !== '0 || ls_log.size() != 0) begin
      failures++;
      $display("FAIL rst_late_rvalid: got req=%b ack=%b acks=%0d expected 0 0 0", mem_req, ls_ack, ls_log.size());
    end
    resp_delay = 0;
    op = '{we: 1'b0, addr: 32'h74, wdata: 32'h0};
    ls_todo.push_back(op);
    serve(40, 0, ok);
    checks++;
    if (!ok || ls_log.size() != 1 || ls_log[0] !== ls_expect(op)) begin
      failures++;
      $display("FAIL rst_recover: got done=%0d acks=%0d expected 1 1 with data for 74", ok, ls_log.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    ls_op_t ls_ops[$];
    logic [AW-1:0] if_ops[$];
    int n_ls, n_if, li, fi, run, max_run, fseen;
    ls_op_t op;
    do_reset();
    n_ls = $urandom_range(12, 20);
    n_if = $urandom_range(6, 10);
    for (int i = 0; i < n_ls; i++) begin
      op.we    = 1'($urandom_range(0, 1));
      op.addr  = AW'($urandom) & 32'h0FFF_FFFC;
      op.wdata = XW'($urandom);
      ls_ops.push_back(op);
      ls_todo.push_back(op);
    end
    for (int i = 0; i < n_if; i++) begin
      if_ops.push_back(32'h1000_0000 | (AW'($urandom) & 32'h00FF_FFF8));
      if_todo.push_back(if_ops[i]);
    end
    ready_rand = 1;
    ls_gaps = 1;
    serve(3000, 1, ok);
    ready_rand = 0;
    ls_gaps = 0;
    resp_delay = 0;
    checks++;
    if (!ok || ls_log.size() != n_ls || if_log.size() != n_if || acc_addr.size() != n_ls + n_if) begin
      failures++;
      $display("FAIL rand_done: got done=%0d acks=%0d valids=%0d issued=%0d expected 1 %0d %0d %0d",
               ok, ls_log.size(), if_log.size(), acc_addr.size(), n_ls, n_if, n_ls + n_if);
      return;
    end
    foreach (ls_ops[k]) begin
      checks++;
      if (ls_log[k] !== ls_expect(ls_ops[k])) begin
        failures++;
        $display("FAIL rand_ls_rdata[%0d]: got %h expected %h", k, ls_log[k], ls_expect(ls_ops[k]));
      end
    end
    foreach (if_ops[k]) begin
      checks++;
      if (if_log[k] !== mem_word(if_ops[k])) begin
        failures++;
        $display("FAIL rand_if_inst[%0d]: got %h expected %h", k, if_log[k], mem_word(if_ops[k]));
      end
    end
    li = 0; fi = 0; run = 0; max_run = 0; fseen = 0;
    foreach (acc_addr[k]) begin
      checks++;
      if (acc_addr[k][28]) begin
        if (acc_addr[k] !== if_ops[fi] || acc_we[k] !== 1'b0) begin
          failures++;
          $display("FAIL rand_fetch_issue[%0d]: got addr=%h we=%b expected %h 0", k, acc_addr[k], acc_we[k], if_ops[fi]);
        end
        fi++;
        fseen++;
        run = 0;
      end else begin
        if (li >= n_ls || acc_addr[k] !== ls_ops[li].addr || acc_we[k] !== ls_ops[li].we ||
            acc_wdata[k] !== ls_ops[li].wdata) begin
          failures++;
          $display("FAIL rand_ls_issue[%0d]: got addr=%h we=%b wdata=%h expected op %0d", k, acc_addr[k],
                   acc_we[k], acc_wdata[k], li);
        end
        li++;
        if (fseen < n_if) run++;
        if (run > max_run) max_run = run;
      end
    end
    checks++;
    if (max_run > STARVE) begin
      failures++;
      $display("FAIL rand_starve_bound: got %0d LS grants in a row expected at most %0d", max_run, STARVE);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_collision();
    test_back_to_back();
    test_starvation();
    test_flush_wait();
    test_flush_idle();
    test_backpressure();
    test_reset_wait();
    for (int r = 0; r < 3; r++) test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
